alu_issue_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_op_decode.sv | 64 ++++++
 rtl/alu_issue_ctrl.sv | 104 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue front end.
//   - ALU opcode encodings ({funct7[5], funct3})
//   - RV32I major opcodes that the front end accepts
//   - issue FSM state encoding
//   - operand-B source select produced by the decoder
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXEC = 3'd1;
  localparam logic [2:0] ST_CAPT = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_ILL  = 3'd4;

  localparam logic [1:0] IMM_REG = 2'd0;  // opB = rs2_data
  localparam logic [1:0] IMM_I   = 2'd1;  // opB = sext(instr[31:20])
  localparam logic [1:0] IMM_U   = 2'd2;  // opB = {instr[31:12], 12'h0}

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode for the ALU subset.
//   instr    in  32  instruction word
//   legal    out 1   instruction is supported
//   alu_op   out 4   ALU opcode
//   imm_sel  out 2   operand-B source (IMM_REG / IMM_I / IMM_U)
//   opa_zero out 1   operand A forced to zero (LUI)
//   rd       out 5   destination register
import alu_pkg::*;

module alu_op_decode (
  input  logic [31:0] instr,
  output logic        legal,
  output logic [3:0]  alu_op,
  output logic [1:0]  imm_sel,
  output logic        opa_zero,
  output logic [4:0]  rd
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  // Register/immediate fields are consumed by the operand mux in the top.
  assign unused_bits = ^instr[24:15];

  always_comb begin
    legal    = 1'b0;
    alu_op   = ALU_ADD;
    imm_sel  = IMM_REG;
    opa_zero = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_op = {1'b0, funct3};
        if (funct7 == 7'b0000000) begin
          legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal  = 1'b1;
          alu_op = ALU_SUB;
        end
      end
      OPC_OPIMM: begin
        imm_sel = IMM_I;
        // immediate bit 30 is data, never the sub/sra selector
        alu_op  = {1'b0, funct3};
        case (funct3)
          3'b000, 3'b100, 3'b110, 3'b111: legal = 1'b1;
          3'b001, 3'b101:                 legal = (funct7 == 7'b0000000);
          default:                        legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal    = 1'b1;
        imm_sel  = IMM_U;
        opa_zero = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue front end of the registered ALU.
// Accepts one instruction + operands (in_valid/in_ready), drives the ALU for
// one cycle (EXEC), captures the ALU's registered result (CAPT) and offers it
// as a writeback beat (wb_valid/wb_ready). Unsupported instructions produce a
// one-cycle illegal pulse instead of a writeback.
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             instruction handshake (ready only in IDLE)
//   instr, rs1_data, rs2_data     instruction and register operands
//   alu_opA/alu_opB/alu_op        ALU drive, held between instructions
//   alu_result                    ALU registered result
//   wb_valid/wb_ready/wb_rd/wb_data  writeback beat
//   illegal                       one-cycle pulse on unsupported instruction
import alu_pkg::*;

module alu_issue_ctrl #(
  parameter logic SUPPRESS_X0 = 1'b1,
  parameter logic SHAMT_MASK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal
);

  logic [2:0]  state, state_nxt;
  logic        dec_legal, dec_opa_zero, is_shift, accept;
  logic [3:0]  dec_op;
  logic [1:0]  dec_imm_sel;
  logic [4:0]  dec_rd;
  logic [31:0] opb_raw, opb_nxt, opa_nxt;

  alu_op_decode u_dec (
    .instr    (instr),
    .legal    (dec_legal),
    .alu_op   (dec_op),
    .imm_sel  (dec_imm_sel),
    .opa_zero (dec_opa_zero),
    .rd       (dec_rd)
  );

  always_comb begin
    case (dec_imm_sel)
      IMM_I:   opb_raw = {{20{instr[31]}}, instr[31:20]};
      IMM_U:   opb_raw = {instr[31:12], 12'h000};
      default: opb_raw = rs2_data;
    endcase
  end

  // The ALU shifts by the full opB; masking restores RV32I shamt semantics
  // for register shifts with rs2 >= 32.
  assign is_shift = (dec_op == ALU_SLL) || (dec_op == ALU_SRL);
  assign opb_nxt  = (SHAMT_MASK && is_shift) ? (opb_raw & 32'h0000_001F) : opb_raw;
  assign opa_nxt  = dec_opa_zero ? 32'h0 : rs1_data;

  assign in_ready = (state == ST_IDLE);
  assign wb_valid = (state == ST_WB);
  assign illegal  = (state == ST_ILL);
  assign accept   = in_valid && (state == ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = dec_legal ? ST_EXEC : ST_ILL;
      ST_EXEC: state_nxt = ST_CAPT;
      ST_CAPT: state_nxt = (SUPPRESS_X0 && wb_rd == 5'd0) ? ST_IDLE : ST_WB;
      ST_WB:   if (wb_ready) state_nxt = ST_IDLE;
      ST_ILL:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      alu_opA <= '0;
      alu_opB <= '0;
      alu_op  <= ALU_ADD;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept && dec_legal) begin
        alu_opA <= opa_nxt;
        alu_opB <= opb_nxt;
        alu_op  <= dec_op;
        wb_rd   <= dec_rd;
      end
      if (state == ST_CAPT) wb_data <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_valid2 = 1'b0;
  logic [31:0] instr = '0, rs1_data = '0, rs2_data = '0;
  logic        wb_ready = 1'b0;
  logic        wb_ready2 = 1'b1;

  logic        in_ready, wb_valid, illegal;
  logic [31:0] alu_opA, alu_opB, wb_data, alu_result;
  logic [3:0]  alu_op;
  logic [4:0]  wb_rd;

  logic        in_ready2, wb_valid2, illegal2;
  logic [31:0] alu_opA2, alu_opB2, wb_data2, alu_result2;
  logic [3:0]  alu_op2;
  logic [4:0]  wb_rd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_op(alu_op), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal)
  );

  alu_issue_ctrl #(.SUPPRESS_X0(1'b0), .SHAMT_MASK(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_opA(alu_opA2), .alu_opB(alu_opB2), .alu_op(alu_op2), .alu_result(alu_result2),
    .wb_valid(wb_valid2), .wb_ready(wb_ready2), .wb_rd(wb_rd2), .wb_data(wb_data2),
    .illegal(illegal2)
  );

  // Registered ALU that shifts by the full 32-bit opB.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return (b > 32'd31) ? 32'h0 : a << b[4:0];
      4'b0100: return a ^ b;
      4'b0101: return (b > 32'd31) ? 32'h0 : a >> b[4:0];
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_result  <= alu_f(alu_op, alu_opA, alu_opB);
    alu_result2 <= alu_f(alu_op2, alu_opA2, alu_opB2);
  end

  // Reference: what an RV32I core would compute for the supported subset.
  function automatic void ref_model(input logic [31:0] ins, r1, r2, input bit mask,
                                    output bit legal, output logic [3:0] op,
                                    output logic [31:0] a, b, res);
    logic [6:0] f7;
    logic [2:0] f3;
    int unsigned sh;
    f7 = ins[31:25];
    f3 = ins[14:12];
    legal = 0; op = 4'h0; a = 0; b = 0; res = 0;
    if (ins[6:0] == 7'b0110011) begin
      a = r1; b = r2; op = {f7[5], f3};
      legal = (f7 == 7'h00 && f3 != 3'd2 && f3 != 3'd3) || (f7 == 7'h20 && f3 == 3'd0);
    end else if (ins[6:0] == 7'b0010011) begin
      a = r1; b = {{20{ins[31]}}, ins[31:20]}; op = {1'b0, f3};
      legal = (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7) ||
              ((f3 == 3'd1 || f3 == 3'd5) && f7 == 7'h00);
    end else if (ins[6:0] == 7'b0110111) begin
      legal = 1; a = 0; b = {ins[31:12], 12'h0}; res = b; return;
    end
    if (!legal) return;
    if ((f3 == 3'd1 || f3 == 3'd5) && mask) b = b % 32;
    sh = b;
    case (f3)
      3'd0: res = (op == 4'b1000) ? a - b : a + b;
      3'd1: res = (sh >= 32) ? 0 : a << sh;
      3'd4: res = a ^ b;
      3'd5: res = (sh >= 32) ? 0 : a >> sh;
      3'd6: res = a | b;
      default: res = a & b;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0, 1: w[6:0] = 7'b0110011;
      2, 3: w[6:0] = 7'b0010011;
      4:    w[6:0] = 7'b0110111;
      default: w[6:0] = ($urandom_range(0, 1) == 0) ? 7'b0000011 : 7'b1100011;
    endcase
    case ($urandom_range(0, 3))
      0, 1: w[31:25] = 7'h00;
      2:    w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // Issue one instruction to dut from IDLE (called at a negedge) and follow it
  // to completion, checking every cycle against the reference model.
  task automatic run_one(input logic [31:0] ins, r1, r2, input int stall, input string nm);
    bit legal;
    logic [3:0] eop;
    logic [31:0] ea, eb, eres;
    ref_model(ins, r1, r2, 1'b1, legal, eop, ea, eb, eres);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s idle_ready: got %b want 1", nm, in_ready); end
    instr = ins; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; instr = $urandom; rs1_data = $urandom; rs2_data = $urandom;
    wb_ready = 1'($urandom_range(0, 1));  // no effect while wb_valid is low
    if (!legal) begin
      checks++;
      if ({illegal, in_ready, wb_valid} !== 3'b100) begin
        errors++; $display("FAIL %s ill_pulse: got ill/rdy/wbv=%b%b%b want 100", nm, illegal, in_ready, wb_valid);
      end
      @(negedge clk);
      checks++;
      if ({illegal, in_ready, wb_valid} !== 3'b010) begin
        errors++; $display("FAIL %s ill_end: got ill/rdy/wbv=%b%b%b want 010", nm, illegal, in_ready, wb_valid);
      end
      return;
    end
    checks++;
    if ({alu_op, alu_opA, alu_opB} !== {eop, ea, eb} || {in_ready, wb_valid, illegal} !== 3'b000) begin
      errors++;
      $display("FAIL %s exec: got op=%h a=%h b=%h rdy/wbv/ill=%b%b%b want op=%h a=%h b=%h 000",
               nm, alu_op, alu_opA, alu_opB, in_ready, wb_valid, illegal, eop, ea, eb);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, wb_valid} !== 2'b00) begin
      errors++; $display("FAIL %s capt: got rdy/wbv=%b%b want 00", nm, in_ready, wb_valid);
    end
    wb_ready = 1'b0;
    @(negedge clk);
    if (ins[11:7] == 5'd0) begin
      checks++;
      if ({in_ready, wb_valid} !== 2'b10) begin
        errors++; $display("FAIL %s x0_skip: got rdy/wbv=%b%b want 10", nm, in_ready, wb_valid);
      end
      return;
    end
    checks++;
    if ({wb_valid, in_ready, wb_rd, wb_data} !== {2'b10, ins[11:7], eres}) begin
      errors++; $display("FAIL %s wb: got v=%b rdy=%b rd=%0d data=%h want v=1 rdy=0 rd=%0d data=%h",
                         nm, wb_valid, in_ready, wb_rd, wb_data, ins[11:7], eres);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if ({wb_valid, wb_rd, wb_data} !== {1'b1, ins[11:7], eres}) begin
        errors++; $display("FAIL %s wb_hold%0d: got v=%b rd=%0d data=%h want v=1 rd=%0d data=%h",
                           nm, i, wb_valid, wb_rd, wb_data, ins[11:7], eres);
      end
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    checks++;
    if ({wb_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL %s wb_done: got wbv/rdy=%b%b want 01", nm, wb_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready, wb_valid, illegal, alu_op, alu_opA, alu_opB, wb_rd, wb_data} !==
        {3'b100, 4'h0, 32'h0, 32'h0, 5'h0, 32'h0}) begin
      errors++; $display("FAIL reset: got rdy=%b wbv=%b ill=%b op=%h a=%h b=%h rd=%0d d=%h want all zero, rdy=1",
                         in_ready, wb_valid, illegal, alu_op, alu_opA, alu_opB, wb_rd, wb_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();  run_one(32'h002081B3, 32'd5, 32'd7, 0, "add"); endtask
  task automatic test_sub();  run_one(32'h402081B3, 32'd5, 32'd7, 0, "sub"); endtask
  task automatic test_sll();  run_one(32'h002091B3, 32'd1, 32'h21, 0, "sll"); endtask
  task automatic test_lui();  run_one(32'h123452B7, 32'hDEAD_BEEF, 32'h1, 0, "lui"); endtask
  task automatic test_illegal(); run_one(32'h4020D1B3, 32'h8000_0000, 32'd1, 0, "sra"); endtask
  task automatic test_stall(); run_one(32'h002081B3, 32'd100, 32'd23, 4, "stall"); endtask
  task automatic test_x0();   run_one(32'h00208033, 32'd9, 32'd9, 0, "x0"); endtask

  // Unmasked instance: rs2=0x21 reaches the ALU whole, so sll shifts everything out.
  task automatic test_shamt_nomask();
    instr = 32'h002091B3; rs1_data = 32'd1; rs2_data = 32'h21; in_valid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 1'b0;
    checks++;
    if (alu_opB2 !== 32'h21) begin errors++; $display("FAIL nomask_opB: got %h want 00000021", alu_opB2); end
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_valid2, wb_rd2, wb_data2} !== {1'b1, 5'd3, 32'h0}) begin
      errors++; $display("FAIL nomask_wb: got v=%b rd=%0d d=%h want v=1 rd=3 d=0", wb_valid2, wb_rd2, wb_data2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);  // CAPT
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, wb_valid, illegal, alu_op, alu_opA, alu_opB, wb_rd, wb_data} !==
        {3'b100, 4'h0, 32'h0, 32'h0, 5'h0, 32'h0}) begin
      errors++; $display("FAIL reset_mid: got rdy=%b wbv=%b ill=%b op=%h a=%h b=%h rd=%0d d=%h want reset values",
                         in_ready, wb_valid, illegal, alu_op, alu_opA, alu_opB, wb_rd, wb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({wb_valid, illegal, in_ready} !== 3'b001) begin
        errors++; $display("FAIL reset_mid_quiet%0d: got wbv/ill/rdy=%b%b%b want 001", i, wb_valid, illegal, in_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++)
      run_one(rand_instr(), $urandom, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
              $urandom_range(0, 3), "rand");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_sll();
    test_shamt_nomask();
    test_lui();
    test_illegal();
    test_stall();
    test_x0();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
